// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: request/ready handshake between the control unit and instruction/data memory.
// Ports: imem_req/imem_ready (fetch), dmem_req/dmem_we/dmem_ready (load/store).
// master = control unit (drives requests), slave = memory side (drives ready).
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input  imem_ready, input dmem_ready);
  modport slave  (input  imem_req, input dmem_req, input dmem_we,
                  output imem_ready, output dmem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core.
// Latency (zero-wait memory): BRANCH 3, R/I/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5 cycles.
// Backpressure: requests held until the matching ready; TIMEOUT_CYC wait cycles -> FAULT (0 = never).
// Ports: clk, rst_n, run, opcode, branch_taken; mem (handshake interface, master side);
//   ir_write, reg_write, pc_write, pc_src (strobes); alu_src, mem_to_reg, jump, auipc (level
//   controls); state, instret, mem_timeout, illegal_instr (status).
// Option: define MCU_ILLEGAL_TRAP_EN to halt in TRAP on an illegal opcode instead of skipping it.
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [6:0]                opcode,
  input  logic                      branch_taken,
  multicycle_control_unit_if.master mem,
  output logic                      ir_write,
  output logic                      reg_write,
  output logic                      alu_src,
  output logic                      mem_to_reg,
  output logic                      jump,
  output logic                      auipc,
  output logic                      pc_write,
  output logic [1:0]                pc_src,
  output logic [2:0]                state,
  output logic [CNT_W-1:0]          instret,
  output logic                      mem_timeout,
  output logic                      illegal_instr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_FAULT  = 3'd6, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  // Wait counter only needs to reach TIMEOUT_CYC-1; the next non-ready cycle faults.
  localparam int WC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t          st;
  cls_t            cls;
  cls_t            d_cls;
  logic [WC_W-1:0] wcnt;
  logic            imem_req_q, dmem_req_q, dmem_we_q;
  logic            wait_expired;
  logic            ill_nop;
  logic            retire;

  always_comb begin
    d_cls = C_ILL;
    case (opcode)
      7'b0110011: d_cls = C_R;
      7'b0010011: d_cls = C_I;
      7'b0000011: d_cls = C_LOAD;
      7'b0100011: d_cls = C_STORE;
      7'b1100011: d_cls = C_BRANCH;
      7'b1101111: d_cls = C_JAL;
      7'b1100111: d_cls = C_JALR;
      7'b0110111: d_cls = C_LUI;
      7'b0010111: d_cls = C_AUIPC;
      default:    d_cls = C_ILL;
    endcase
  end

`ifdef MCU_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_instr = illegal_q;
  assign ill_nop       = 1'b0;
`else
  assign illegal_instr = 1'b0;
  assign ill_nop       = (cls == C_ILL);
`endif

  assign wait_expired = (TIMEOUT_CYC != 0) && (wcnt == WC_LAST);

  // Strobes answer a same-cycle ready / compare result, so they decode registered state.
  assign ir_write  = (st == S_FETCH) && mem.imem_ready;
  assign reg_write = (st == S_WB);
  assign pc_write  = ((st == S_EXEC) && ((cls == C_BRANCH) || ill_nop)) ||
                     ((st == S_MEM) && mem.dmem_ready && (cls == C_STORE)) ||
                     (st == S_WB);
  // A skipped illegal opcode updates the PC but is not an instruction retirement.
  assign retire    = pc_write && !((st == S_EXEC) && (cls == C_ILL));

  always_comb begin
    pc_src = 2'd0;
    if ((st == S_EXEC) && (cls == C_BRANCH)) pc_src = {1'b0, branch_taken};
    else if ((st == S_WB) && (cls == C_JAL))  pc_src = 2'd1;
    else if ((st == S_WB) && (cls == C_JALR)) pc_src = 2'd2;
  end

  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign state        = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      cls         <= C_ILL;
      wcnt        <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      alu_src     <= 1'b0;
      mem_to_reg  <= 1'b0;
      jump        <= 1'b0;
      auipc       <= 1'b0;
      instret     <= '0;
      mem_timeout <= 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (run) begin
            st         <= S_FETCH;
            imem_req_q <= 1'b1;
            wcnt       <= '0;
          end
        end
        S_FETCH: begin
          if (mem.imem_ready) begin
            st         <= S_DECODE;
            imem_req_q <= 1'b0;
          end else if (wait_expired) begin
            st          <= S_FAULT;
            imem_req_q  <= 1'b0;
            mem_timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DECODE: begin
          cls        <= d_cls;
          alu_src    <= d_cls inside {C_I, C_LOAD, C_STORE, C_JAL, C_JALR, C_LUI, C_AUIPC};
          mem_to_reg <= (d_cls == C_LOAD);
          jump       <= (d_cls == C_JAL) || (d_cls == C_JALR);
          auipc      <= (d_cls == C_AUIPC);
          st         <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_LOAD, C_STORE: begin
              st         <= S_MEM;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (cls == C_STORE);
              wcnt       <= '0;
            end
            C_BRANCH: ;  // retired by the pc_write path below
            C_ILL: begin
`ifdef MCU_ILLEGAL_TRAP_EN
              st        <= S_TRAP;
              illegal_q <= 1'b1;
`endif
            end
            default: st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (cls == C_LOAD) st <= S_WB;
          end else if (wait_expired) begin
            st          <= S_FAULT;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WB:    ;  // retired by the pc_write path below
        S_FAULT: ;
        S_TRAP:  ;
        default: st <= S_IDLE;
      endcase

      // Every final pc_write ends the instruction: start the next fetch or park in IDLE.
      if (pc_write) begin
        st         <= run ? S_FETCH : S_IDLE;
        imem_req_q <= run;
        dmem_req_q <= 1'b0;
        dmem_we_q  <= 1'b0;
        wcnt       <= '0;
        alu_src    <= 1'b0;
        mem_to_reg <= 1'b0;
        jump       <= 1'b0;
        auipc      <= 1'b0;
      end
      if (retire) instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed scoreboard bench for multicycle_control_unit.
// Stimulus pushes per-instruction expectations; a monitor checks them at each pc_write pulse.
// A memory responder raises ready a programmed number of cycles after each request.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        branch_taken = 1'b0;
  logic        ir_write, reg_write, alu_src, mem_to_reg, jump, auipc, pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        mem_timeout, illegal_instr;

  multicycle_control_unit_if mem_if();

  multicycle_control_unit #(.CNT_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem(mem_if), .ir_write(ir_write), .reg_write(reg_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .jump(jump), .auipc(auipc), .pc_write(pc_write),
    .pc_src(pc_src), .state(state), .instret(instret), .mem_timeout(mem_timeout),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [1:0]  src;
    int          rwc;
    logic        m2r, jmp, alu, au;
    int          lat, dreq, dwe;
    logic [31:0] ir;
  } exp_t;

  exp_t expq[$];
  int   passed = 0;
  int   total  = 0;
  int   idly   = 0;
  int   ddly   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(input string name, input logic [2:0] st, input logic [1:0] src,
                              input int rwc, input logic m2r, input logic jmp, input logic alu,
                              input logic au, input int lat, input int dreq, input int dwe,
                              input logic [31:0] ir);
    exp_t e;
    e.name = name; e.st = st; e.src = src; e.rwc = rwc; e.m2r = m2r; e.jmp = jmp;
    e.alu = alu; e.au = au; e.lat = lat; e.dreq = dreq; e.dwe = dwe; e.ir = ir;
    return e;
  endfunction

  // Memory model: ready after N wait cycles of a held request.
  initial begin
    int icnt = 0;
    int dcnt = 0;
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_if.imem_req) begin mem_if.imem_ready = (icnt == idly); icnt++; end
      else begin mem_if.imem_ready = 1'b0; icnt = 0; end
      if (mem_if.dmem_req) begin mem_if.dmem_ready = (dcnt == ddly); dcnt++; end
      else begin mem_if.dmem_ready = 1'b0; dcnt = 0; end
    end
  end

  // Monitor: per-instruction cycle/strobe accounting, compared at the final pc_write.
  initial begin
    int lat = 0, dreq = 0, dwe = 0, rwc = 0;
    logic [2:0] prev = 3'd0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin lat = 0; dreq = 0; dwe = 0; rwc = 0; prev = 3'd0; continue; end
      if (state == 3'd1 && prev != 3'd1) begin lat = 0; dreq = 0; dwe = 0; rwc = 0; end
      lat++;
      if (mem_if.dmem_req) dreq++;
      if (mem_if.dmem_we)  dwe++;
      if (reg_write)       rwc++;
      if (pc_write) begin
        if (expq.size() == 0) check("unexpected_pc_write", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          check({e.name, ".state"},      32'(state),      32'(e.st));
          check({e.name, ".pc_src"},     32'(pc_src),     32'(e.src));
          check({e.name, ".reg_writes"}, 32'(rwc),        32'(e.rwc));
          check({e.name, ".mem_to_reg"}, 32'(mem_to_reg), 32'(e.m2r));
          check({e.name, ".jump"},       32'(jump),       32'(e.jmp));
          check({e.name, ".alu_src"},    32'(alu_src),    32'(e.alu));
          check({e.name, ".auipc"},      32'(auipc),      32'(e.au));
          check({e.name, ".cycles"},     32'(lat),        32'(e.lat));
          check({e.name, ".dmem_req"},   32'(dreq),       32'(e.dreq));
          check({e.name, ".dmem_we"},    32'(dwe),        32'(e.dwe));
          check({e.name, ".instret"},    instret,         e.ir);
        end
      end
      prev = state;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin @(negedge clk); #1; n++; end
    if (expq.size() != 0) begin
      check("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
  endtask

  task automatic do_instr(input logic [6:0] op, input int id, input int dd, input logic tk,
                          input exp_t e, input logic stop);
    opcode = op; idly = id; ddly = dd; branch_taken = tk;
    expq.push_back(e);
    if (stop) begin @(posedge clk); #1; run = 1'b0; end
    wait_drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; idly = 0; ddly = 0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [17:0] all_outs();
    return {mem_if.imem_req, ir_write, mem_if.dmem_req, mem_if.dmem_we, reg_write, alu_src,
            mem_to_reg, jump, auipc, pc_write, pc_src, state, mem_timeout, illegal_instr, 1'b0};
  endfunction

  initial begin
    int n;
    int fcnt;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(all_outs()), 32'd0);
    check("reset_instret", instret, 32'd0);
    rst_n = 1'b1;

    // Reset while a LOAD is waiting in MEM.
    opcode = 7'b0000011; ddly = 1000; run = 1'b1;
    n = 0;
    while (mem_if.dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("reach_mem_before_reset", 32'(mem_if.dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1;
    check("reset_state_next_clk", 32'(state), 32'd0);
    check("reset_instret_mid_mem", instret, 32'd0);
    @(negedge clk);
    ddly = 0; rst_n = 1'b1;
    run = 1'b1;

    do_instr(7'b0110011, 0, 0, 1'b0, mk("r_type",  5, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0), 1'b0);
    do_instr(7'b0000011, 0, 3, 1'b0, mk("load_w3", 5, 0, 1, 1, 0, 1, 0, 8, 4, 0, 1), 1'b0);
    do_instr(7'b1100011, 0, 0, 1'b1, mk("br_tkn",  3, 1, 0, 0, 0, 0, 0, 3, 0, 0, 2), 1'b0);
    do_instr(7'b1100011, 0, 0, 1'b0, mk("br_ntkn", 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3), 1'b0);
    do_instr(7'b0100011, 0, 0, 1'b0, mk("store",   4, 0, 0, 0, 0, 1, 0, 4, 1, 1, 4), 1'b0);
    do_instr(7'b1101111, 0, 0, 1'b0, mk("jal",     5, 1, 1, 0, 1, 1, 0, 4, 0, 0, 5), 1'b0);
    do_instr(7'b1100111, 0, 0, 1'b0, mk("jalr",    5, 2, 1, 0, 1, 1, 0, 4, 0, 0, 6), 1'b0);
    do_instr(7'b0010111, 2, 0, 1'b0, mk("auipc_w2",5, 0, 1, 0, 0, 1, 1, 6, 0, 0, 7), 1'b0);
    do_instr(7'b0110111, 0, 0, 1'b0, mk("lui",     5, 0, 1, 0, 0, 1, 0, 4, 0, 0, 8), 1'b0);
    do_instr(7'b0010011, 0, 0, 1'b0, mk("i_alu",   5, 0, 1, 0, 0, 1, 0, 4, 0, 0, 9), 1'b1);

    // run dropped during the last instruction: park in IDLE after it retires.
    @(posedge clk); #1;
    check("park_idle_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    check("park_idle_hold", 32'(state), 32'd0);
    check("park_idle_imem_req", 32'(mem_if.imem_req), 32'd0);
    check("park_idle_instret", instret, 32'd10);

    // Fetch timeout with TIMEOUT_CYC = 4.
    idly = 1000; run = 1'b1;
    fcnt = 0; n = 0;
    while (state !== 3'd6 && n < 30) begin
      @(negedge clk);
      if (state == 3'd1) fcnt++;
      n++;
    end
    check("timeout_state", 32'(state), 32'd6);
    check("timeout_fetch_cycles", 32'(fcnt), 32'd4);
    check("timeout_flag", 32'(mem_timeout), 32'd1);
    check("timeout_imem_req", 32'(mem_if.imem_req), 32'd0);
    repeat (5) @(negedge clk);
    check("fault_hold_state", 32'(state), 32'd6);
    check("fault_hold_imem_req", 32'(mem_if.imem_req), 32'd0);
    check("fault_instret", instret, 32'd10);

    do_reset();
    check("post_fault_reset_flag", 32'(mem_timeout), 32'd0);

`ifdef MCU_ILLEGAL_TRAP_EN
    opcode = 7'b1111111; run = 1'b1;
    n = 0;
    while (state !== 3'd7 && n < 20) begin @(negedge clk); n++; end
    check("trap_state", 32'(state), 32'd7);
    check("trap_flag", 32'(illegal_instr), 32'd1);
    check("trap_instret", instret, 32'd0);
    repeat (4) @(negedge clk);
    check("trap_hold_state", 32'(state), 32'd7);
    check("trap_hold_flag", 32'(illegal_instr), 32'd1);
`else
    run = 1'b1;
    do_instr(7'b1111111, 0, 0, 1'b0, mk("illegal_nop", 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0), 1'b0);
    do_instr(7'b0110011, 0, 0, 1'b0, mk("r_after_ill", 5, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0), 1'b0);
    check("illegal_flag_tied", 32'(illegal_instr), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder for the sequential RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready-handshakes to instruction and data memory.
- Registers the decoded control bits, drives PC update and pulsed write enables, and counts retired instructions.
- Detects stalled memory with a bounded wait timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter `instret` (wraps modulo 2^CNT_W).
- TIMEOUT_CYC, 16, maximum wait cycles in FETCH/MEM before fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable; when low, the FSM parks in IDLE after the current instruction retires.
- opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE.
- imem_ready  in  1  instruction memory data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- branch_taken  in  1  ALU compare result; sampled in EXEC for branches.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the instruction register (1-cycle pulse).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier.
- reg_write  out  1  register-file write (1-cycle pulse, WB only).
- alu_src  out  1  ALU operand-B selects immediate.
- mem_to_reg  out  1  writeback selects memory data.
- jump  out  1  current instruction is JAL/JALR.
- auipc  out  1  ALU operand-A selects PC.
- pc_write  out  1  update PC (1-cycle pulse).
- pc_src  out  2  PC source: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR).
- state  out  3  current FSM state encoding.
- instret  out  CNT_W  retired-instruction count.
- mem_timeout  out  1  sticky memory-timeout flag.
- illegal_instr  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (asynchronous):
  - State = IDLE (0).
  - Every output = 0, including `instret`, the wait counter and both sticky flags.
  - Any in-flight request is dropped.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, FAULT 6, TRAP 7.
- IDLE:
  - run = 1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - `imem_req` = 1 and held until `imem_ready`.
  - On the `imem_ready` cycle: `ir_write` = 1, then -> DECODE.
  - Wait counter increments each non-ready cycle.
  - Counter reaching TIMEOUT_CYC -> FAULT.
- DECODE (1 cycle):
  - Latches the decode class and the control bits.
  - R (0110011): reg_write.
  - I-ALU (0010011): reg_write, alu_src.
  - LOAD (0000011): reg_write, alu_src, mem_to_reg.
  - STORE (0100011): alu_src.
  - BRANCH (1100011): no level bits.
  - JAL (1101111) and JALR (1100111): jump, alu_src.
  - LUI (0110111): alu_src.
  - AUIPC (0010111): auipc, alu_src.
  - Any other opcode is illegal.
  - Level outputs (alu_src, mem_to_reg, jump, auipc) are driven from EXEC through the end of the instruction and cleared in FETCH.
- EXEC (1 cycle):
  - LOAD/STORE -> MEM.
  - BRANCH: `pc_write` = 1, `pc_src` = branch_taken ? 1 : 0, retire, -> FETCH.
  - Other legal opcodes -> WB.
- MEM:
  - `dmem_req` = 1, `dmem_we` = 1 for STORE; both held until `dmem_ready`.
  - Same timeout rule as FETCH.
  - On `dmem_ready`: LOAD -> WB; STORE: `pc_write` = 1, `pc_src` = 0, retire, -> FETCH.
- WB (1 cycle):
  - `reg_write` = 1 and `pc_write` = 1.
  - `pc_src` = 1 for JAL, 2 for JALR, 0 otherwise.
  - Retire, -> FETCH.
- Retire:
  - `instret` += 1 in the same cycle as the final `pc_write`.
  - Next state is IDLE instead of FETCH if run = 0 on that cycle.
- Wait counter:
  - Clears on entry to FETCH and MEM.
  - Ready asserted in the same cycle the counter would hit TIMEOUT_CYC takes precedence: no fault.
- FAULT:
  - `mem_timeout` = 1; all request and strobe outputs = 0.
  - Exit only via reset.
- Latency with zero-wait memory:
  - R, I-ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- `imem_ready`/`dmem_ready` asserted outside their own state are ignored.

Optional Feature:
- Macro: MCU_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode moves EXEC -> TRAP.
  - `illegal_instr` = 1 (sticky); no `pc_write`, no retire.
  - FSM holds in TRAP until reset.
- Undefined: an illegal opcode is treated as a NOP.
  - In EXEC: `pc_write` = 1, `pc_src` = 0, -> FETCH, not counted in `instret`.
  - `illegal_instr` is tied to 0; TRAP is unreachable.

Test Plan:
1. Reset mid-MEM, with `dmem_req` high on a LOAD: assert rst_n = 0 -> all outputs 0 immediately, state = 0 next clock, `instret` = 0.
2. R-type 0110011, zero-wait memory, run = 1 -> state sequence 1,2,3,5; `reg_write` and `pc_write` pulse in WB with `pc_src` = 0; `instret` 0 -> 1.
3. LOAD, `dmem_ready` delayed 3 cycles -> `dmem_req` high for 4 cycles with `dmem_we` = 0, then WB with `mem_to_reg` = 1 and `reg_write` pulse; total 8 cycles.
4. BRANCH with branch_taken = 1, then BRANCH with branch_taken = 0 -> `pc_src` = 1 then 0 in EXEC; `reg_write` never asserted; 3 cycles each.
5. TIMEOUT_CYC = 4, `imem_ready` held 0 -> state = 6 after 4 FETCH wait cycles, `mem_timeout` = 1, `imem_req` = 0 and stays there until reset.
6. Opcode 1111111 -> with MCU_ILLEGAL_TRAP_EN: state = 7, `illegal_instr` = 1, `instret` unchanged; without the macro: `pc_write` in EXEC, back to FETCH, `instret` unchanged.
